// File: rtl/can_tx_fifo.sv
// can_tx_fifo: transmit message FIFO feeding the TX priority logic.
// Host writes ID, DLC and DW1 into staging registers. A DW2 write commits
// all four words as one 128-bit entry. The head entry is always presented
// on o_fifo_data (first-word-fall-through) and is popped by i_rd_en.
module can_tx_fifo #(
  parameter int DEPTH       = 64,
  parameter int AFULL_LEVEL = 48
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [1:0]               i_wr_addr,
  input  logic [31:0]              i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_clr_ovf,
  output logic [127:0]             o_fifo_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ADDR_ID  = 2'd0;
  localparam logic [1:0] ADDR_DLC = 2'd1;
  localparam logic [1:0] ADDR_DW1 = 2'd2;
  localparam logic [1:0] ADDR_DW2 = 2'd3;

  logic [31:0]   stageId_q, stageDlc_q, stageDw1_q;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [127:0]  mem [DEPTH];

  logic          isEmpty, isFull;
  logic          commitReq, pushOk, pushDrop, popOk;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CW'(DEPTH));

  // A commit request is any DW2 write; flush swallows it without side effects.
  // Full is judged on the registered count, before any same-cycle pop.
  assign commitReq = i_wr_en && (i_wr_addr == ADDR_DW2) && !i_flush;
  assign pushOk    = commitReq && !isFull;
  assign pushDrop  = commitReq && isFull;
  assign popOk     = i_rd_en && !isEmpty && !i_flush;

  // Staging registers: loaded by host writes, untouched by commit or flush.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      stageId_q  <= '0;
      stageDlc_q <= '0;
      stageDw1_q <= '0;
    end else if (i_wr_en) begin
      if (i_wr_addr == ADDR_ID)  stageId_q  <= i_wr_data;
      if (i_wr_addr == ADDR_DLC) stageDlc_q <= i_wr_data;
      if (i_wr_addr == ADDR_DW1) stageDw1_q <= i_wr_data;
    end
  end

  // Entry storage: not reset, stale contents are masked by the empty flag.
  always_ff @(posedge i_sys_clk) begin
    if (pushOk) begin
      mem[wrPtr_q] <= {stageId_q, stageDlc_q, stageDw1_q, i_wr_data};
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
      if (popOk)  rdPtr_d = rdPtr_q + AW'(1);
      if (pushOk && !popOk)      count_d = count_q + CW'(1);
      else if (!pushOk && popOk) count_d = count_q - CW'(1);
    end

    if (pushDrop)       overflow_d = 1'b1;
    else if (i_clr_ovf) overflow_d = 1'b0;
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    o_fifo_data   = isEmpty ? '0 : mem[rdPtr_q];
    o_empty       = isEmpty;
    o_full        = isFull;
    o_almost_full = (count_q >= CW'(AFULL_LEVEL));
    o_count       = count_q;
    o_overflow    = overflow_q;
  end

endmodule

// File: tb/tb_can_tx_fifo.sv
// tb_can_tx_fifo: directed self-checking bench for can_tx_fifo (64 deep).
module tb_can_tx_fifo;

  localparam int DEPTH = 64;
  localparam int AFULL = 48;

  logic         i_sys_clk;
  logic         i_reset;
  logic         i_flush;
  logic         i_wr_en;
  logic [1:0]   i_wr_addr;
  logic [31:0]  i_wr_data;
  logic         i_rd_en;
  logic         i_clr_ovf;
  logic [127:0] o_fifo_data;
  logic         o_empty;
  logic         o_full;
  logic         o_almost_full;
  logic [6:0]   o_count;
  logic         o_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [127:0] modelQ[$];
  logic         modelOvf;
  logic [31:0]  stId, stDlc, stDw1;

  can_tx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .i_sys_clk    (i_sys_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rd_en      (i_rd_en),
    .i_clr_ovf    (i_clr_ovf),
    .o_fifo_data  (o_fifo_data),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_almost_full(o_almost_full),
    .o_count      (o_count),
    .o_overflow   (o_overflow)
  );

  // 100 MHz system clock
  initial begin
    i_sys_clk = 1'b0;
    forever #5 i_sys_clk = ~i_sys_clk;
  end

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // DUT against the reference model: count, empty, head, overflow
  task automatic checkModel(input string tag);
    logic [127:0] head;
    head = (modelQ.size() == 0) ? 128'd0 : modelQ[0];
    checkOutput({tag, ".count"}, 128'(o_count), 128'(modelQ.size()));
    checkOutput({tag, ".empty"}, 128'(o_empty), 128'(modelQ.size() == 0));
    checkOutput({tag, ".head"}, o_fifo_data, head);
    checkOutput({tag, ".ovf"}, 128'(o_overflow), 128'(modelOvf));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".data"},  o_fifo_data, 128'd0);
    checkOutput({tag, ".empty"}, 128'(o_empty), 128'd1);
    checkOutput({tag, ".full"},  128'(o_full), 128'd0);
    checkOutput({tag, ".afull"}, 128'(o_almost_full), 128'd0);
    checkOutput({tag, ".count"}, 128'(o_count), 128'd0);
    checkOutput({tag, ".ovf"},   128'(o_overflow), 128'd0);
  endtask

  // One clock of stimulus: drive on the falling edge, release 1 ns after the rising edge
  task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                               input logic rd, input logic flush, input logic clr);
    logic wasFull, wasEmpty, commit;
    @(negedge i_sys_clk);
    i_wr_en   = wr;
    i_wr_addr = addr;
    i_wr_data = data;
    i_rd_en   = rd;
    i_flush   = flush;
    i_clr_ovf = clr;
    @(posedge i_sys_clk);
    #1;
    i_wr_en   = 1'b0;
    i_rd_en   = 1'b0;
    i_flush   = 1'b0;
    i_clr_ovf = 1'b0;
    // model update
    commit   = wr && (addr == 2'd3) && !flush;
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    if (wr && !flush) begin
      if (addr == 2'd0) stId  = data;
      if (addr == 2'd1) stDlc = data;
      if (addr == 2'd2) stDw1 = data;
    end else if (wr && flush) begin
      if (addr == 2'd0) stId  = data;
      if (addr == 2'd1) stDlc = data;
      if (addr == 2'd2) stDw1 = data;
    end
    if (flush) begin
      modelQ.delete();
    end else begin
      if (rd && !wasEmpty) void'(modelQ.pop_front());
      if (commit && !wasFull) modelQ.push_back({stId, stDlc, stDw1, data});
    end
    if (commit && wasFull) modelOvf = 1'b1;
    else if (clr)          modelOvf = 1'b0;
  endtask

  task automatic writeStage(input logic [31:0] id, input logic [31:0] dlc, input logic [31:0] dw1);
    applyStimulus(1'b1, 2'd0, id,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, dlc, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, dw1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pushed;
    int popSeq;
    int cyc;
    logic doPush, doPop;

    i_reset   = 1'b1;
    i_flush   = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_addr = 2'd0;
    i_wr_data = 32'd0;
    i_rd_en   = 1'b0;
    i_clr_ovf = 1'b0;
    modelOvf  = 1'b0;
    stId = 0; stDlc = 0; stDw1 = 0;

    // Reset state
    #12;
    checkResetValues("reset");
    @(negedge i_sys_clk);
    i_reset = 1'b0;

    // Single message
    writeStage(32'h1234_0000, 32'h8000_0000, 32'hAAAA_5555);
    applyStimulus(1'b1, 2'd3, 32'h0102_0304, 1'b0, 1'b0, 1'b0);
    checkOutput("single.empty", 128'(o_empty), 128'd0);
    checkOutput("single.count", 128'(o_count), 128'd1);
    checkOutput("single.data", o_fifo_data, 128'h1234_0000_8000_0000_AAAA_5555_0102_0304);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("pop.empty", 128'(o_empty), 128'd1);
    checkOutput("pop.data", o_fifo_data, 128'd0);

    // Pop on empty is harmless
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkModel("popEmpty");

    // Fill to full, watching the almost-full and full thresholds
    writeStage(32'hCAFE_0001, 32'h0000_0008, 32'hDEAD_BEEF);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 2'd3, 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill.count", 128'(o_count), 128'(i + 1));
      checkOutput("fill.afull", 128'(o_almost_full), 128'((i + 1) >= AFULL));
      checkOutput("fill.full", 128'(o_full), 128'((i + 1) == DEPTH));
    end
    checkOutput("fill.head", o_fifo_data, {32'hCAFE_0001, 32'h0000_0008, 32'hDEAD_BEEF, 32'd0});
    applyStimulus(1'b1, 2'd3, 32'd64, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf.count", 128'(o_count), 128'd64);
    checkOutput("ovf.flag", 128'(o_overflow), 128'd1);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("clrovf.flag", 128'(o_overflow), 128'd0);

    // Push and pop together while full: push rejected, pop happens
    applyStimulus(1'b1, 2'd3, 32'd99, 1'b1, 1'b0, 1'b0);
    checkOutput("fullPP.count", 128'(o_count), 128'd63);
    checkOutput("fullPP.ovf", 128'(o_overflow), 128'd1);
    checkOutput("fullPP.head", o_fifo_data, {32'hCAFE_0001, 32'h0000_0008, 32'hDEAD_BEEF, 32'd1});
    checkModel("fullPP");

    // Set-wins when a dropped push and a clear coincide
    applyStimulus(1'b1, 2'd3, 32'd100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'd101, 1'b0, 1'b0, 1'b1);
    checkOutput("setWins.ovf", 128'(o_overflow), 128'd1);

    // Flush with 10 entries while committing; overflow stays set
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    writeStage(32'h0000_0ABC, 32'h0000_0004, 32'h1111_2222);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd3, 32'(i + 200), 1'b0, 1'b0, 1'b0);
    checkOutput("pre.count", 128'(o_count), 128'd10);
    applyStimulus(1'b1, 2'd3, 32'd500, 1'b1, 1'b1, 1'b0);
    checkOutput("flush.count", 128'(o_count), 128'd0);
    checkOutput("flush.empty", 128'(o_empty), 128'd1);
    checkOutput("flush.ovf", 128'(o_overflow), 128'd1);
    applyStimulus(1'b1, 2'd3, 32'h0000_0077, 1'b0, 1'b0, 1'b1);
    checkOutput("stageKeep.data", o_fifo_data, 128'h0000_0ABC_0000_0004_1111_2222_0000_0077);
    checkOutput("stageKeep.ovf", 128'(o_overflow), 128'd0);

    // Push and pop while empty: count becomes 1
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'd300, 1'b1, 1'b0, 1'b0);
    checkOutput("emptyPP.count", 128'(o_count), 128'd1);
    checkOutput("emptyPP.head", o_fifo_data, 128'h0000_0ABC_0000_0004_1111_2222_0000_012C);

    // Push and pop with 5 entries: count stays, head advances
    for (int i = 1; i < 5; i++) applyStimulus(1'b1, 2'd3, 32'(300 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'd305, 1'b1, 1'b0, 1'b0);
    checkOutput("midPP.count", 128'(o_count), 128'd5);
    checkOutput("midPP.head", o_fifo_data, 128'h0000_0ABC_0000_0004_1111_2222_0000_012D);
    checkModel("midPP");

    // Ordered stream across pointer wrap, 200 messages
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    pushed = 0;
    popSeq = 0;
    cyc    = 0;
    while (popSeq < 200 && cyc < 2000) begin
      doPush = (pushed < 200) && (modelQ.size() < DEPTH) && (cyc % 5 != 4);
      doPop  = (modelQ.size() > 0) && ((pushed >= 200) || (cyc % 3 == 0));
      if (doPop) checkOutput("wrap.dw2", 128'(o_fifo_data[31:0]), 128'(popSeq));
      applyStimulus(doPush, 2'd3, 32'(pushed), doPop, 1'b0, 1'b0);
      if (doPush) pushed++;
      if (doPop)  popSeq++;
      checkOutput("wrap.count", 128'(o_count), 128'(modelQ.size()));
      cyc++;
    end
    checkOutput("wrap.done", 128'(popSeq), 128'd200);
    checkModel("wrapEnd");

    // Asynchronous reset in the middle of a commit burst
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd3, 32'(i + 900), 1'b0, 1'b0, 1'b0);
    checkOutput("burst.count", 128'(o_count), 128'd3);
    @(negedge i_sys_clk);
    i_wr_en   = 1'b1;
    i_wr_addr = 2'd3;
    i_wr_data = 32'd999;
    @(posedge i_sys_clk);
    #2;
    i_reset = 1'b1;
    #1;
    checkResetValues("asyncReset");
    @(negedge i_sys_clk);
    i_wr_en = 1'b0;
    i_reset = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    stId = 0; stDlc = 0; stDw1 = 0;
    applyStimulus(1'b1, 2'd3, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
    checkOutput("postReset.data", o_fifo_data, 128'h55);
    checkModel("postReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_fifo.md
# can_tx_fifo

Transmit message FIFO that sits directly upstream of the TX priority logic in the system-clock domain. Host software writes each CAN message as four 32-bit words: ID, DLC, DW1, DW2. The block assembles each message into one 128-bit entry and commits it when DW2 is written. The FIFO is first-word-fall-through: the head entry is always presented on the output, and the priority logic pops it with a single-cycle read strobe.

## Interface
- DEPTH, 64, number of 128-bit entries; power of two, ≥ 2
- AFULL_LEVEL, 48, `o_almost_full` asserts when occupancy ≥ this value; range 1..DEPTH
- i_sys_clk  in  1  system clock; all logic on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  synchronous clear of FIFO contents
- i_wr_en  in  1  host register write strobe
- i_wr_addr  in  2  word select: 0=ID, 1=DLC, 2=DW1, 3=DW2 (commit)
- i_wr_data  in  32  host write data
- i_rd_en  in  1  pop strobe, driven by the priority logic's FIFO read enable
- i_clr_ovf  in  1  clears the sticky overflow flag
- o_fifo_data  out  128  head entry: [127:96]=ID, [95:64]=DLC, [63:32]=DW1, [31:0]=DW2
- o_empty  out  1  FIFO empty; feeds the priority logic's tx-empty input
- o_full  out  1  occupancy == DEPTH
- o_almost_full  out  1  occupancy ≥ AFULL_LEVEL
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_overflow  out  1  sticky flag: a commit was dropped because the FIFO was full

## Operation
- **Staging registers.** Three 32-bit registers hold ID, DLC and DW1.
  - A write with `i_wr_addr` 0, 1 or 2 loads the matching register.
  - Staging registers are never cleared by a commit or by flush. A message may reuse a previous ID/DLC without rewriting them.
- **Commit.** A write with `i_wr_addr`=3:
  - If not full: push {ID, DLC, DW1, `i_wr_data`} at the write pointer. The write pointer increments modulo DEPTH.
  - If full: the entry is dropped, `o_overflow` is set, and the pointers are unchanged.
- **Pop.**
  - `i_rd_en` while not empty: the read pointer increments modulo DEPTH.
  - `i_rd_en` while empty: ignored, no error.
- **Output data.** `o_fifo_data` = mem[rd_ptr] when not empty; all zeros when empty. It is a combinational read of registered state, with no latency beyond the pointer update.
- **Occupancy.** `o_count` is a registered counter.
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
  - `o_empty`, `o_full` and `o_almost_full` are decoded from the registered count.
- **Simultaneous push and pop.**
  - When full: the push is rejected and `o_overflow` is set, because full is evaluated before the pop. The pop still occurs, so the count becomes DEPTH−1.
  - When empty: the push succeeds and the pop is ignored, so the count becomes 1.
- **Flush.** `i_flush` zeroes both pointers and the count on the next edge.
  - Flush has priority over any same-cycle push or pop.
  - A push dropped by flush does not set `o_overflow`.
  - Flush does not clear `o_overflow`.
- **Overflow flag.** `o_overflow` is cleared by `i_clr_ovf`. If set and clear occur in the same cycle, set wins.
- **Reset.** Asynchronous reset zeroes the pointers, count, staging registers and overflow flag. Memory contents are not reset and are masked by `o_empty`.
- **Outputs during reset:** `o_fifo_data`=0, `o_empty`=1, `o_full`=0, `o_almost_full`=0, `o_count`=0, `o_overflow`=0.

## Timing
- **Commit latency.** A commit sampled at edge N makes `o_empty`=0, `o_count`+1 and `o_fifo_data` valid in the cycle after edge N. That is one cycle of write-to-visible latency.
- **Pop latency.** A pop sampled at edge N makes the next entry, or zero if the FIFO is now empty, appear on `o_fifo_data` after edge N. The priority logic therefore sees the new head one cycle after its read strobe.
- **Back-to-back operation.** A push and a pop are each accepted every cycle. No bubbles are required.
- **Priority logic handshake.**
  - The priority logic latches `o_fifo_data` while `o_empty`=0 and pops exactly once per message.
  - The block must hold the head entry stable until it is popped.
- **Reset mid-operation.** Outputs reach their reset values asynchronously. Normal operation resumes at the first clock edge after `i_reset` deasserts.

## Test plan
- **Single message.** After reset, write ID=0x1234_0000, DLC=0x8000_0000, DW1=0xAAAA_5555, DW2=0x0102_0304.
  - One cycle after the DW2 write: `o_empty`=0, `o_count`=1, `o_fifo_data`=0x1234_0000_8000_0000_AAAA_5555_0102_0304.
  - Pulse `i_rd_en`: the next cycle shows `o_empty`=1 and `o_fifo_data`=0.
- **Fill, overflow and clear** (DEPTH=64, AFULL_LEVEL=48).
  - Commit 64 messages, DW2=index: `o_almost_full` rises at count 48 and `o_full` at count 64.
  - A 65th commit leaves `o_count`=64 and sets `o_overflow`=1.
  - `i_clr_ovf` returns `o_overflow` to 0.
- **Order and wrap-around.** Interleave pushes and pops across 200 messages with DW2 = sequence number.
  - Popped DW2 values increment strictly by 1 across pointer wrap.
  - `o_count` matches the reference model every cycle.
- **Simultaneous events.**
  - Push and pop when full: count goes to 63 and `o_overflow`=1.
  - Push and pop when empty: count goes to 1.
  - Push and pop with count 5: count stays 5, and the head advances to the next entry.
- **Flush and reset.**
  - With 10 entries, assert `i_flush` together with a commit: count is 0, `o_empty`=1, `o_overflow` unchanged, and the staging registers retain ID/DLC/DW1.
  - Assert `i_reset` asynchronously mid-burst: all outputs are at reset values before the next clock edge.
